// File: rtl/prn_reclaim_queue_pkg.sv
// Shared types and sizes for the PRN reclaim queue and its rename-side consumer.
package prn_reclaim_queue_pkg;

  localparam int unsigned PRN_BITS     = 6;
  localparam int unsigned MAX_OPERANDS = 3;
  localparam int unsigned DEPTH        = 16;
  localparam int unsigned RETIRE_WIDTH = 2;
  localparam int unsigned FREE_SLOTS   = MAX_OPERANDS * RETIRE_WIDTH;
  localparam int unsigned IDX_W        = $clog2(DEPTH);
  localparam int unsigned PTR_W        = IDX_W + 1;

  typedef struct packed {
    logic [MAX_OPERANDS-1:0]               prn_valid;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] new_prn;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] old_prn;
  } reclaim_entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WALK = 1'b1
  } rq_state_e;

endpackage

// File: rtl/prn_reclaim_queue.sv
// In-order PRN bookkeeping queue: frees stale PRNs at commit and squashed
// allocations on a flush walk, onto the rename stage's free bus.
module prn_reclaim_queue
  import prn_reclaim_queue_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  alloc_valid_i,
  output logic                                  alloc_ready_o,
  input  logic [MAX_OPERANDS-1:0]               alloc_prn_valid_i,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] alloc_new_prn_i,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] alloc_old_prn_i,
  output logic [IDX_W-1:0]                      alloc_tag_o,
  input  logic [1:0]                            commit_count_i,
  input  logic                                  flush_i,
  output logic [FREE_SLOTS-1:0]                 free_valid_o,
  output logic [FREE_SLOTS-1:0][PRN_BITS-1:0]   free_prns_o,
  output logic [PTR_W-1:0]                      occupancy_o,
  output logic                                  walking_o
);

  rq_state_e                            state_q;
  logic [PTR_W-1:0]                     head_q, head_d;
  logic [PTR_W-1:0]                     tail_q, tail_d;
  logic [PTR_W-1:0]                     occ;
  logic [PTR_W-1:0]                     commit_n;
  logic [PTR_W-1:0]                     walk_n;
  logic [1:0]                           cnt_req;
  logic                                 enq;
  logic [FREE_SLOTS-1:0]                free_valid_q, free_valid_d;
  logic [FREE_SLOTS-1:0][PRN_BITS-1:0]  free_prns_q, free_prns_d;
  reclaim_entry_t                       mem_q [DEPTH];

  assign occ           = tail_q - head_q;
  assign alloc_ready_o = !rst && (state_q == ST_IDLE) && (occ < PTR_W'(DEPTH));
  assign enq           = alloc_valid_i && alloc_ready_o && !flush_i;
  assign alloc_tag_o   = tail_q[IDX_W-1:0];
  assign occupancy_o   = occ;
  assign walking_o     = (state_q == ST_WALK);
  assign free_valid_o  = free_valid_q;
  assign free_prns_o   = free_prns_q;

  // A request of 3 saturates to the retire width; never release past the tail.
  assign cnt_req  = (commit_count_i == 2'd3) ? 2'd2 : commit_count_i;
  assign commit_n = (PTR_W'(cnt_req) > occ) ? occ : PTR_W'(cnt_req);
  assign walk_n   = (occ > PTR_W'(RETIRE_WIDTH)) ? PTR_W'(RETIRE_WIDTH) : occ;

  // Slot packer and pointer update: commit pops oldest-first, walk pops youngest-first.
  always_comb begin
    free_valid_d = '0;
    free_prns_d  = '0;
    head_d       = head_q;
    tail_d       = tail_q;
    if (state_q == ST_IDLE) begin
      for (int k = 0; k < RETIRE_WIDTH; k++) begin
        if (PTR_W'(k) < commit_n) begin
          for (int j = 0; j < MAX_OPERANDS; j++) begin
            if (mem_q[IDX_W'(head_q + PTR_W'(k))].prn_valid[j]) begin
              free_valid_d[k*MAX_OPERANDS+j] = 1'b1;
              free_prns_d[k*MAX_OPERANDS+j]  = mem_q[IDX_W'(head_q + PTR_W'(k))].old_prn[j];
            end
          end
        end
      end
      head_d = head_q + commit_n;
      tail_d = tail_q + PTR_W'(enq);
    end else begin
      for (int k = 0; k < RETIRE_WIDTH; k++) begin
        if (PTR_W'(k) < walk_n) begin
          for (int j = 0; j < MAX_OPERANDS; j++) begin
            if (mem_q[IDX_W'(tail_q - PTR_W'(k + 1))].prn_valid[j]) begin
              free_valid_d[k*MAX_OPERANDS+j] = 1'b1;
              free_prns_d[k*MAX_OPERANDS+j]  = mem_q[IDX_W'(tail_q - PTR_W'(k + 1))].new_prn[j];
            end
          end
        end
      end
      tail_d = tail_q - walk_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      head_q       <= '0;
      tail_q       <= '0;
      free_valid_q <= '0;
      free_prns_q  <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      free_valid_q <= free_valid_d;
      free_prns_q  <= free_prns_d;
      case (state_q)
        ST_IDLE: if (flush_i && (tail_d != head_d)) state_q <= ST_WALK;
        ST_WALK: if (tail_d == head_q) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Entry storage needs no reset: only slots between head and tail are ever read.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[IDX_W'(tail_q)] <= '{prn_valid: alloc_prn_valid_i,
                                 new_prn:   alloc_new_prn_i,
                                 old_prn:   alloc_old_prn_i};
    end
  end

endmodule
